// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel processing pipeline: operation encodings,
// gray weighting shift and a saturation helper.
package pixel_pkg;

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_BR_ADD = 3'd1,
    MODE_BR_SUB = 3'd2,
    MODE_GRAY   = 3'd3,
    MODE_INV    = 3'd4,
    MODE_THR    = 3'd5
  } mode_e;

  // gray = (R + 2G + B) >> GRAY_SHIFT
  localparam int GRAY_SHIFT = 2;

  localparam int SAT_W = 32;

  function automatic logic [SAT_W-1:0] saturate(input logic             overflow,
                                                input logic [SAT_W-1:0] value,
                                                input logic [SAT_W-1:0] limit);
    return overflow ? limit : value;
  endfunction

endpackage

// File: rtl/pixel_lane_op.sv
// Stage-2 point operator for a single pixel: selects the processed value for
// each channel from the stage-1 precomputed gray, sum and difference.
module pixel_lane_op
  import pixel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int THRESH     = 90
) (
  input  logic [2:0]            mode,
  input  logic [DATA_WIDTH-1:0] r_in,
  input  logic [DATA_WIDTH-1:0] g_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] gray,
  input  logic [DATA_WIDTH:0]   sum_r,
  input  logic [DATA_WIDTH:0]   sum_g,
  input  logic [DATA_WIDTH:0]   sum_b,
  input  logic [DATA_WIDTH:0]   diff_r,
  input  logic [DATA_WIDTH:0]   diff_g,
  input  logic [DATA_WIDTH:0]   diff_b,
  output logic [DATA_WIDTH-1:0] r_out,
  output logic [DATA_WIDTH-1:0] g_out,
  output logic [DATA_WIDTH-1:0] b_out
);

  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH:0] s);
    return DATA_WIDTH'(saturate(s[DATA_WIDTH], SAT_W'(s[DATA_WIDTH-1:0]), SAT_W'(ONES)));
  endfunction

  // The borrow bit of the difference flags an underflow, which clamps to zero
  function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH:0] d);
    return DATA_WIDTH'(saturate(d[DATA_WIDTH], SAT_W'(d[DATA_WIDTH-1:0]), '0));
  endfunction

  logic [DATA_WIDTH-1:0] thr;

  always_comb begin
    thr   = (gray >= DATA_WIDTH'(THRESH)) ? ONES : '0;
    r_out = r_in;
    g_out = g_in;
    b_out = b_in;
    case (mode)
      MODE_BR_ADD: begin
        r_out = sat_add(sum_r);
        g_out = sat_add(sum_g);
        b_out = sat_add(sum_b);
      end
      MODE_BR_SUB: begin
        r_out = sat_sub(diff_r);
        g_out = sat_sub(diff_g);
        b_out = sat_sub(diff_b);
      end
      MODE_GRAY: begin
        r_out = gray;
        g_out = gray;
        b_out = gray;
      end
      MODE_INV: begin
        r_out = r_in ^ ONES;
        g_out = g_in ^ ONES;
        b_out = b_in ^ ONES;
      end
      MODE_THR: begin
        r_out = thr;
        g_out = thr;
        b_out = thr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pixel_proc_pipe.sv
// Two-stage stall-able streaming pixel processor with line/frame markers.
// Define PIXEL_PROC_STATS_EN to add per-frame gray min/max statistics ports.
module pixel_proc_pipe
  import pixel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int IMG_W      = 768,
  parameter int IMG_H      = 512,
  parameter int THRESH     = 90
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic [2:0]                  mode,
  input  logic [DATA_WIDTH-1:0]       bright_val,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_hsync,
  input  logic [LANES*DATA_WIDTH-1:0] in_r,
  input  logic [LANES*DATA_WIDTH-1:0] in_g,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_hsync,
  output logic [LANES*DATA_WIDTH-1:0] out_r,
  output logic [LANES*DATA_WIDTH-1:0] out_g,
  output logic [LANES*DATA_WIDTH-1:0] out_b,
  output logic                        out_eol,
  output logic                        out_eof,
  output logic                        frame_done
`ifdef PIXEL_PROC_STATS_EN
  ,
  output logic [DATA_WIDTH-1:0]       stat_min,
  output logic [DATA_WIDTH-1:0]       stat_max,
  output logic                        stat_valid
`endif
);

  localparam int COLS = IMG_W / LANES;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DW   = DATA_WIDTH;
  localparam int PW   = LANES * DW;
  localparam int SW   = LANES * (DW + 1);

  typedef struct packed {
    logic          valid;
    logic          hsync;
    logic          eol;
    logic          eof;
    logic [2:0]    mode;
    logic [PW-1:0] r, g, b, gray;
    logic [SW-1:0] sum_r, sum_g, sum_b, diff_r, diff_g, diff_b;
  } s1_t;

  typedef struct packed {
    logic          valid;
    logic          hsync;
    logic          eol;
    logic          eof;
    logic [PW-1:0] r, g, b;
  } s2_t;

  s1_t           s1_q, s1_d;
  s2_t           s2_q, s2_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0]    mode_lat_q, mode_lat_d, beat_mode;
  logic [DW-1:0] bv_lat_q, bv_lat_d, beat_bv;
  logic          adv, accept, last_col, last_row, first_beat;
  logic [DW-1:0] r_px, g_px, b_px;
  logic [PW-1:0] gray_in, op_r, op_g, op_b;
  logic [SW-1:0] sum_r_in, sum_g_in, sum_b_in, diff_r_in, diff_g_in, diff_b_in;

  assign in_ready   = adv && !HRESET;
  assign frame_done = s2_q.valid && out_ready && s2_q.eof;

  // The first beat of a frame uses the live mode/offset; later beats use the latch
  always_comb begin
    adv        = !s2_q.valid || out_ready;
    accept     = in_valid && in_ready;
    last_col   = (col_q == CW'(COLS - 1));
    last_row   = (row_q == RW'(IMG_H - 1));
    first_beat = (col_q == '0) && (row_q == '0);
    beat_mode  = first_beat ? mode : mode_lat_q;
    beat_bv    = first_beat ? bright_val : bv_lat_q;
    col_d      = col_q;
    row_d      = row_q;
    mode_lat_d = mode_lat_q;
    bv_lat_d   = bv_lat_q;
    if (accept) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      if (last_col) row_d = last_row ? '0 : row_q + 1'b1;
      if (first_beat) begin
        mode_lat_d = mode;
        bv_lat_d   = bright_val;
      end
    end
  end

  always_comb begin
    r_px      = '0;
    g_px      = '0;
    b_px      = '0;
    gray_in   = '0;
    sum_r_in  = '0;
    sum_g_in  = '0;
    sum_b_in  = '0;
    diff_r_in = '0;
    diff_g_in = '0;
    diff_b_in = '0;
    for (int l = 0; l < LANES; l++) begin
      r_px = in_r[l*DW +: DW];
      g_px = in_g[l*DW +: DW];
      b_px = in_b[l*DW +: DW];
      gray_in[l*DW +: DW] =
        DW'(({2'b00, r_px} + {1'b0, g_px, 1'b0} + {2'b00, b_px}) >> GRAY_SHIFT);
      sum_r_in[l*(DW+1) +: DW+1]  = {1'b0, r_px} + {1'b0, beat_bv};
      sum_g_in[l*(DW+1) +: DW+1]  = {1'b0, g_px} + {1'b0, beat_bv};
      sum_b_in[l*(DW+1) +: DW+1]  = {1'b0, b_px} + {1'b0, beat_bv};
      diff_r_in[l*(DW+1) +: DW+1] = {1'b0, r_px} - {1'b0, beat_bv};
      diff_g_in[l*(DW+1) +: DW+1] = {1'b0, g_px} - {1'b0, beat_bv};
      diff_b_in[l*(DW+1) +: DW+1] = {1'b0, b_px} - {1'b0, beat_bv};
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pixel_lane_op #(.DATA_WIDTH(DW), .THRESH(THRESH)) u_op (
      .mode  (s1_q.mode),
      .r_in  (s1_q.r[l*DW +: DW]),
      .g_in  (s1_q.g[l*DW +: DW]),
      .b_in  (s1_q.b[l*DW +: DW]),
      .gray  (s1_q.gray[l*DW +: DW]),
      .sum_r (s1_q.sum_r[l*(DW+1) +: DW+1]),
      .sum_g (s1_q.sum_g[l*(DW+1) +: DW+1]),
      .sum_b (s1_q.sum_b[l*(DW+1) +: DW+1]),
      .diff_r(s1_q.diff_r[l*(DW+1) +: DW+1]),
      .diff_g(s1_q.diff_g[l*(DW+1) +: DW+1]),
      .diff_b(s1_q.diff_b[l*(DW+1) +: DW+1]),
      .r_out (op_r[l*DW +: DW]),
      .g_out (op_g[l*DW +: DW]),
      .b_out (op_b[l*DW +: DW])
    );
  end

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (adv) begin
      s1_d.valid  = accept;
      s1_d.hsync  = in_hsync;
      s1_d.eol    = accept && last_col;
      s1_d.eof    = accept && last_col && last_row;
      s1_d.mode   = beat_mode;
      s1_d.r      = in_r;
      s1_d.g      = in_g;
      s1_d.b      = in_b;
      s1_d.gray   = gray_in;
      s1_d.sum_r  = sum_r_in;
      s1_d.sum_g  = sum_g_in;
      s1_d.sum_b  = sum_b_in;
      s1_d.diff_r = diff_r_in;
      s1_d.diff_g = diff_g_in;
      s1_d.diff_b = diff_b_in;
      s2_d.valid  = s1_q.valid;
      s2_d.hsync  = s1_q.hsync;
      s2_d.eol    = s1_q.eol;
      s2_d.eof    = s1_q.eof;
      s2_d.r      = op_r;
      s2_d.g      = op_g;
      s2_d.b      = op_b;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      col_q      <= '0;
      row_q      <= '0;
      mode_lat_q <= '0;
      bv_lat_q   <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      mode_lat_q <= mode_lat_d;
      bv_lat_q   <= bv_lat_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid = s2_q.valid;
  assign out_hsync = s2_q.hsync;
  assign out_eol   = s2_q.eol;
  assign out_eof   = s2_q.eof;
  assign out_r     = s2_q.r;
  assign out_g     = s2_q.g;
  assign out_b     = s2_q.b;

`ifdef PIXEL_PROC_STATS_EN
  logic [DW-1:0] trk_min_q, trk_min_d, trk_max_q, trk_max_d, snap_min, snap_max;
  logic [DW-1:0] s1_min_q, s1_min_d, s1_max_q, s1_max_d;
  logic [DW-1:0] s2_min_q, s2_min_d, s2_max_q, s2_max_d;
  logic [DW-1:0] stat_min_q, stat_min_d, stat_max_q, stat_max_d;
  logic          stat_valid_q, stat_valid_d;

  // The frame's final min/max rides along with its eof beat, so early beats of
  // the next frame can be tracked before frame_done publishes the result
  always_comb begin
    snap_min = trk_min_q;
    snap_max = trk_max_q;
    for (int l = 0; l < LANES; l++) begin
      if (gray_in[l*DW +: DW] < snap_min) snap_min = gray_in[l*DW +: DW];
      if (gray_in[l*DW +: DW] > snap_max) snap_max = gray_in[l*DW +: DW];
    end
    trk_min_d = trk_min_q;
    trk_max_d = trk_max_q;
    if (accept) begin
      trk_min_d = (last_col && last_row) ? '1 : snap_min;
      trk_max_d = (last_col && last_row) ? '0 : snap_max;
    end
    s1_min_d     = adv ? snap_min : s1_min_q;
    s1_max_d     = adv ? snap_max : s1_max_q;
    s2_min_d     = adv ? s1_min_q : s2_min_q;
    s2_max_d     = adv ? s1_max_q : s2_max_q;
    stat_valid_d = frame_done;
    stat_min_d   = frame_done ? s2_min_q : stat_min_q;
    stat_max_d   = frame_done ? s2_max_q : stat_max_q;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      trk_min_q    <= '1;
      trk_max_q    <= '0;
      s1_min_q     <= '0;
      s1_max_q     <= '0;
      s2_min_q     <= '0;
      s2_max_q     <= '0;
      stat_min_q   <= '0;
      stat_max_q   <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      trk_min_q    <= trk_min_d;
      trk_max_q    <= trk_max_d;
      s1_min_q     <= s1_min_d;
      s1_max_q     <= s1_max_d;
      s2_min_q     <= s2_min_d;
      s2_max_q     <= s2_max_d;
      stat_min_q   <= stat_min_d;
      stat_max_q   <= stat_max_d;
      stat_valid_q <= stat_valid_d;
    end
  end

  assign stat_min   = stat_min_q;
  assign stat_max   = stat_max_q;
  assign stat_valid = stat_valid_q;
`endif

endmodule

// File: tb/tb_pixel_proc_pipe.sv
// Scoreboard bench for pixel_proc_pipe: directed beats push expected results,
// a negedge monitor pops and compares whenever an output beat is taken.
module tb_pixel_proc_pipe;

  localparam int DW     = 8;
  localparam int LANES  = 1;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int THRESH = 90;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    mode = '0;
  logic [DW-1:0] bright_val = '0;
  logic          in_valid = 1'b0, in_hsync = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic          in_ready, out_valid, out_hsync, out_eol, out_eof, frame_done;
  logic [DW-1:0] out_r, out_g, out_b;
`ifdef PIXEL_PROC_STATS_EN
  logic [DW-1:0] stat_min, stat_max, seen_min, seen_max;
  logic          stat_valid;
  int            stat_seen = 0;
`endif

  typedef struct {
    logic [7:0] r, g, b;
    logic       hsync, eol, eof;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0;
  int   fd_count = 0, exp_frames = 0, col = 0, row = 0;

  always #5 clock = ~clock;

  pixel_proc_pipe #(
    .DATA_WIDTH(DW), .LANES(LANES), .IMG_W(IMG_W), .IMG_H(IMG_H), .THRESH(THRESH)
  ) dut (
    .HCLK(clock), .HRESET(reset), .mode(mode), .bright_val(bright_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_hsync(in_hsync),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_hsync(out_hsync),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done)
`ifdef PIXEL_PROC_STATS_EN
    , .stat_min(stat_min), .stat_max(stat_max), .stat_valid(stat_valid)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic abortRun(input string name);
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired", name);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] aborting run");
  endtask

  function automatic int clip(input int v);
    return (v > 255) ? 255 : ((v < 0) ? 0 : v);
  endfunction

  function automatic exp_t refPix(input int m, input int bv, input int r, input int g, input int b);
    exp_t x;
    int   gr, rr, gg, bb;
    gr = (r + 2 * g + b) / 4;
    rr = r; gg = g; bb = b;
    case (m)
      1: begin rr = clip(r + bv); gg = clip(g + bv); bb = clip(b + bv); end
      2: begin rr = clip(r - bv); gg = clip(g - bv); bb = clip(b - bv); end
      3: begin rr = gr; gg = gr; bb = gr; end
      4: begin rr = 255 - r; gg = 255 - g; bb = 255 - b; end
      5: begin rr = (gr >= THRESH) ? 255 : 0; gg = rr; bb = rr; end
      default: ;
    endcase
    x.r = 8'(rr); x.g = 8'(gg); x.b = 8'(bb);
    x.hsync = 1'b0; x.eol = 1'b0; x.eof = 1'b0;
    return x;
  endfunction

  // Present one beat, wait for it to be taken, and record what must come out
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic hs, input logic [7:0] er, input logic [7:0] eg,
                               input logic [7:0] eb);
    exp_t e;
    int   waits = 0;
    in_r = r; in_g = g; in_b = b; in_hsync = hs; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready) begin
      if (waits == 50) abortRun("in_ready_wait");
      @(negedge clock);
      waits++;
    end
    e.r = er; e.g = eg; e.b = eb; e.hsync = hs;
    e.eol = (col == IMG_W / LANES - 1);
    e.eof = e.eol && (row == IMG_H - 1);
    sb.push_back(e);
    if (e.eol) begin
      col = 0;
      row = (row == IMG_H - 1) ? 0 : row + 1;
      if (e.eof) exp_frames++;
    end else begin
      col++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic sendFillers(input int first, input int last, input int m, input int bv);
    exp_t x;
    for (int i = first; i <= last; i++) begin
      x = refPix(m, bv, i * 30, 250 - i * 20, (i * 53) % 256);
      applyStimulus(8'(i * 30), 8'(250 - i * 20), 8'((i * 53) % 256), i[0], x.r, x.g, x.b);
    end
  endtask

  task automatic drain(input string name);
    int waits = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && waits < 100) begin
      @(posedge clock);
      #1;
      waits++;
    end
    repeat (3) @(posedge clock);
    #1;
    checkOutput({name, "_pending_beats"}, sb.size(), 0);
    checkOutput({name, "_frame_done_count"}, fd_count, exp_frames);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_beat: got r=%0d, expected no output", out_r);
      end else begin
        e = sb.pop_front();
        checkOutput("out_r", out_r, e.r);
        checkOutput("out_g", out_g, e.g);
        checkOutput("out_b", out_b, e.b);
        checkOutput("out_hsync", out_hsync, e.hsync);
        checkOutput("out_eol", out_eol, e.eol);
        checkOutput("out_eof", out_eof, e.eof);
        checkOutput("frame_done", frame_done, e.eof);
      end
    end
    if (frame_done) fd_count++;
`ifdef PIXEL_PROC_STATS_EN
    if (stat_valid) begin
      stat_seen++;
      seen_min = stat_min;
      seen_max = stat_max;
    end
`endif
  end

  initial begin
    $display("[TB] reset phase");
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_r", out_r, 0);
    checkOutput("reset_out_eol", out_eol, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] brightness add and latency");
    mode = 3'd1; bright_val = 8'd100;
    applyStimulus(8'd200, 8'd50, 8'd255, 1'b1, 8'd255, 8'd150, 8'd255);
    in_valid = 1'b0;
    checkOutput("latency_cycle1_valid", out_valid, 0);
    @(posedge clock);
    #1;
    checkOutput("latency_cycle2_valid", out_valid, 1);
    sendFillers(1, 7, 1, 100);
    drain("br_add");

    $display("[TB] brightness subtract, consecutive frame");
    mode = 3'd2;
    applyStimulus(8'd60, 8'd100, 8'd180, 1'b0, 8'd0, 8'd0, 8'd80);
    sendFillers(1, 7, 2, 100);
    drain("br_sub");

    $display("[TB] grayscale");
    mode = 3'd3;
    applyStimulus(8'd40, 8'd80, 8'd120, 1'b0, 8'd80, 8'd80, 8'd80);
    sendFillers(1, 7, 3, 100);
    drain("gray");

    $display("[TB] threshold");
    mode = 3'd5;
    applyStimulus(8'd89, 8'd89, 8'd89, 1'b0, 8'd0, 8'd0, 8'd0);
    applyStimulus(8'd90, 8'd90, 8'd90, 1'b1, 8'd255, 8'd255, 8'd255);
    sendFillers(2, 7, 5, 100);
    drain("threshold");

    $display("[TB] mode change mid-frame");
    mode = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) mode = 3'd4;
      applyStimulus(8'(i * 30), 8'(250 - i * 20), 8'((i * 53) % 256), i[0],
                    8'(i * 30), 8'(250 - i * 20), 8'((i * 53) % 256));
    end
    sendFillers(0, 7, 4, 0);
    drain("mode_switch");

    $display("[TB] backpressure");
    mode = 3'd0;
    fork
      sendFillers(0, 7, 0, 0);
      begin
        logic [7:0] hr, hg, hb;
        logic       he;
        repeat (3) @(posedge clock);
        #1;
        hr = out_r; hg = out_g; hb = out_b; he = out_eol;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          checkOutput("bp_out_valid", out_valid, 1);
          checkOutput("bp_out_r", out_r, hr);
          checkOutput("bp_out_g", out_g, hg);
          checkOutput("bp_out_b", out_b, hb);
          checkOutput("bp_out_eol", out_eol, he);
          checkOutput("bp_in_ready", in_ready, 0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("backpressure");

    $display("[TB] reset mid-frame");
    sendFillers(0, 4, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out_r", out_r, 0);
    checkOutput("midrst_out_g", out_g, 0);
    checkOutput("midrst_out_b", out_b, 0);
    checkOutput("midrst_out_eol", out_eol, 0);
    checkOutput("midrst_out_eof", out_eof, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    sb.delete();
    col = 0;
    row = 0;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sendFillers(0, 7, 0, 0);
    drain("after_reset");

`ifdef PIXEL_PROC_STATS_EN
    $display("[TB] statistics");
    stat_seen = 0;
    for (int k = 1; k <= 8; k++)
      applyStimulus(8'(k * 10), 8'(k * 10), 8'(k * 10), 1'b0, 8'(k * 10), 8'(k * 10), 8'(k * 10));
    drain("stats");
    checkOutput("stat_valid_pulses", stat_seen, 1);
    checkOutput("stat_min", seen_min, 10);
    checkOutput("stat_max", seen_max, 80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
